// File: rtl/hall_velocity_meter_pkg.sv
// Shared definitions for the Hall-sensor velocity meter.
//   HALL_SEQ          forward commutation order of the {A,B,C} Hall code
//   HALL_IDX_INVALID  index returned for codes outside the table (000, 111)
//   DIR_FWD/DIR_REV   encoding of the dir output
//   VEL_W_DEFAULT     default width of the velocity word (also the PID current_vel width)
package hall_velocity_meter_pkg;

    localparam int VEL_W_DEFAULT = 9;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam logic [2:0] HALL_IDX_INVALID = 3'd7;

    localparam logic [2:0] HALL_SEQ [0:5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_FWD,
        EDGE_REV,
        EDGE_ILLEGAL
    } edge_kind_t;

    function automatic logic [2:0] hall_idx(input logic [2:0] code);
        logic [2:0] idx;
        idx = HALL_IDX_INVALID;
        for (int i = 0; i < 6; i++) begin
            if (HALL_SEQ[i] == code) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] idx_next(input logic [2:0] idx);
        return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    endfunction

    function automatic logic [2:0] idx_prev(input logic [2:0] idx);
        return (idx == 3'd0) ? 3'd5 : idx - 3'd1;
    endfunction

endpackage

// File: rtl/hall_velocity_meter_sync.sv
// Two-flop synchronizer for the three raw Hall pins.
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (both stages clear to 000)
//   d      in   raw Hall pins, asynchronous to clk
//   q      out  synchronized Hall code
module hall_velocity_meter_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] d,
    output logic [2:0] q
);

    logic [2:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 3'b000;
            q    <= 3'b000;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hall_velocity_meter.sv
// BLDC rotor speed meter: counts legal Hall commutation edges over a fixed
// gate window and publishes a saturated count, direction and fault flag once
// per window.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   measurement enable
//   hall         in   raw Hall pins {A,B,C}
//   current_vel  out  legal edges in the last completed window (saturated)
//   dir          out  direction of the last legal edge (0 fwd, 1 rev)
//   hall_err     out  illegal code or transition seen in the last window
//   vel_valid    out  one-cycle pulse when the outputs above update
module hall_velocity_meter
    import hall_velocity_meter_pkg::*;
#(
    parameter int WINDOW_CYCLES = 500000,
    parameter int VEL_W         = VEL_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       hall,
    output logic [VEL_W-1:0] current_vel,
    output logic             dir,
    output logic             hall_err,
    output logic             vel_valid
);

    localparam int                WIN_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [VEL_W-1:0]  VEL_MAX  = '1;

    logic [2:0]       hall_s;
    logic [2:0]       hall_p;
    logic [1:0]       prime_cnt;
    logic             primed;
    logic [2:0]       idx_s;
    logic [2:0]       idx_p;
    edge_kind_t       edge_kind;
    logic             legal;
    logic [VEL_W-1:0] cnt;
    logic [VEL_W-1:0] cnt_next;
    logic             err_acc;
    logic             err_next;
    logic             dir_acc;
    logic             dir_next;
    logic [WIN_W-1:0] win_cnt;
    logic             win_last;

    hall_velocity_meter_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (hall),
        .q     (hall_s)
    );

    // hall_p tracks hall_s from the first cycle; edges are only evaluated once
    // the synchronizer has flushed its reset value, so the 000 -> code step
    // after reset is never seen as an illegal edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_p    <= 3'b000;
            prime_cnt <= 2'd0;
            primed    <= 1'b0;
        end else begin
            hall_p <= hall_s;
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
                primed    <= (prime_cnt == 2'd2);
            end
        end
    end

    assign idx_s = hall_idx(hall_s);
    assign idx_p = hall_idx(hall_p);

    always_comb begin
        edge_kind = EDGE_NONE;
        if (primed && (hall_s != hall_p)) begin
            if ((idx_s == HALL_IDX_INVALID) || (idx_p == HALL_IDX_INVALID)) begin
                edge_kind = EDGE_ILLEGAL;
            end else if (idx_s == idx_next(idx_p)) begin
                edge_kind = EDGE_FWD;
            end else if (idx_s == idx_prev(idx_p)) begin
                edge_kind = EDGE_REV;
            end else begin
                edge_kind = EDGE_ILLEGAL;
            end
        end
    end

    assign legal    = (edge_kind == EDGE_FWD) || (edge_kind == EDGE_REV);
    assign cnt_next = (legal && (cnt != VEL_MAX)) ? cnt + VEL_W'(1) : cnt;
    assign err_next = err_acc | (edge_kind == EDGE_ILLEGAL);
    assign dir_next = (edge_kind == EDGE_FWD) ? DIR_FWD :
                      (edge_kind == EDGE_REV) ? DIR_REV : dir_acc;
    assign win_last = (win_cnt == WIN_LAST);

    // The terminal cycle publishes the "_next" values, so an edge evaluated in
    // that same cycle lands in the closing window while the accumulators
    // restart from zero for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt     <= '0;
            cnt         <= '0;
            err_acc     <= 1'b0;
            dir_acc     <= DIR_FWD;
            current_vel <= '0;
            dir         <= DIR_FWD;
            hall_err    <= 1'b0;
            vel_valid   <= 1'b0;
        end else if (!en) begin
            win_cnt   <= '0;
            cnt       <= '0;
            err_acc   <= 1'b0;
            vel_valid <= 1'b0;
        end else if (win_last) begin
            win_cnt     <= '0;
            cnt         <= '0;
            err_acc     <= 1'b0;
            dir_acc     <= dir_next;
            current_vel <= cnt_next;
            dir         <= dir_next;
            hall_err    <= err_next;
            vel_valid   <= 1'b1;
        end else begin
            win_cnt   <= win_cnt + WIN_W'(1);
            cnt       <= cnt_next;
            err_acc   <= err_next;
            dir_acc   <= dir_next;
            vel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hall_velocity_meter.sv
module tb_hall_velocity_meter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] hall;
    logic [8:0] current_vel;
    logic       dir;
    logic       hall_err;
    logic       vel_valid;

    logic       rst_n_big;
    logic       en_big;
    logic [2:0] hall_big;
    logic [8:0] current_vel_big;
    logic       dir_big;
    logic       hall_err_big;
    logic       vel_valid_big;

    int vectors;
    int miscompares;
    int rel;
    int pos;

    logic [2:0] seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    int         cap_t   [$];
    logic [8:0] cap_vel [$];
    logic       cap_dir [$];
    logic       cap_err [$];

    hall_velocity_meter #(.WINDOW_CYCLES(100), .VEL_W(9)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .hall        (hall),
        .current_vel (current_vel),
        .dir         (dir),
        .hall_err    (hall_err),
        .vel_valid   (vel_valid)
    );

    hall_velocity_meter #(.WINDOW_CYCLES(2000), .VEL_W(9)) u_dut_big (
        .clk         (clk),
        .rst_n       (rst_n_big),
        .en          (en_big),
        .hall        (hall_big),
        .current_vel (current_vel_big),
        .dir         (dir_big),
        .hall_err    (hall_err_big),
        .vel_valid   (vel_valid_big)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_caps();
        cap_t.delete();
        cap_vel.delete();
        cap_dir.delete();
        cap_err.delete();
    endtask

    task automatic step(input bit rev);
        pos  = rev ? (pos + 5) % 6 : (pos + 1) % 6;
        hall = seq[pos];
    endtask

    // Advance n cycles, recording each vel_valid pulse, stepping the rotor every
    // 'period' cycles (0 = no stepping); ph0 presets the step phase.
    task automatic run(input int n, input int period, input bit rev, input int ph0);
        int ph;
        ph = ph0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rel++;
            if (vel_valid === 1'b1) begin
                cap_t.push_back(rel);
                cap_vel.push_back(current_vel);
                cap_dir.push_back(dir);
                cap_err.push_back(hall_err);
            end
            if (period > 0) begin
                ph++;
                if (ph == period) begin
                    ph = 0;
                    step(rev);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rst_n_big = 1'b0;
        en        = 1'b1;
        en_big    = 1'b0;
        pos       = 0;
        hall      = seq[0];
        hall_big  = seq[0];
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (current_vel !== 9'd0) begin miscompares++; $display("FAIL reset_vel: got %0d expected 0", current_vel); end
        vectors++; if (dir !== 1'b0) begin miscompares++; $display("FAIL reset_dir: got %b expected 0", dir); end
        vectors++; if (hall_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", hall_err); end
        vectors++; if (vel_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", vel_valid); end
        vectors++; if (current_vel_big !== 9'd0) begin miscompares++; $display("FAIL reset_vel_big: got %0d expected 0", current_vel_big); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel   = 0;
        clear_caps();
        run(250, 0, 1'b0, 0);
        vectors++; if (cap_t.size() !== 2) begin miscompares++; $display("FAIL idle_pulses: got %0d expected 2", cap_t.size()); end
        for (int i = 0; i < cap_t.size() && i < 2; i++) begin
            vectors++; if (cap_t[i] !== 100 * (i + 1)) begin miscompares++; $display("FAIL idle_t[%0d]: got %0d expected %0d", i, cap_t[i], 100 * (i + 1)); end
            vectors++; if (cap_vel[i] !== 9'd0) begin miscompares++; $display("FAIL idle_vel[%0d]: got %0d expected 0", i, cap_vel[i]); end
            vectors++; if (cap_dir[i] !== 1'b0) begin miscompares++; $display("FAIL idle_dir[%0d]: got %b expected 0", i, cap_dir[i]); end
            vectors++; if (cap_err[i] !== 1'b0) begin miscompares++; $display("FAIL idle_err[%0d]: got %b expected 0", i, cap_err[i]); end
        end
    endtask

    task automatic test_forward();
        rel = 0;
        clear_caps();
        run(360, 10, 1'b0, 0);
        vectors++; if (cap_t.size() !== 4) begin miscompares++; $display("FAIL fwd_pulses: got %0d expected 4", cap_t.size()); end
        for (int i = 0; i < cap_t.size() && i < 4; i++) begin
            vectors++; if (cap_t[i] !== 50 + 100 * i) begin miscompares++; $display("FAIL fwd_t[%0d]: got %0d expected %0d", i, cap_t[i], 50 + 100 * i); end
            if (i > 0) begin
                vectors++; if (cap_vel[i] !== 9'd10) begin miscompares++; $display("FAIL fwd_vel[%0d]: got %0d expected 10", i, cap_vel[i]); end
                vectors++; if (cap_dir[i] !== 1'b0) begin miscompares++; $display("FAIL fwd_dir[%0d]: got %b expected 0", i, cap_dir[i]); end
                vectors++; if (cap_err[i] !== 1'b0) begin miscompares++; $display("FAIL fwd_err[%0d]: got %b expected 0", i, cap_err[i]); end
            end
        end
    endtask

    // Steps at 7, 27, ... 187: the step at 187 is evaluated in the terminal
    // cycle of the window closing at 190. First window also holds 2 forward
    // edges left over from the previous test.
    task automatic test_reverse();
        logic [8:0] exp_vel;
        rel = 0;
        clear_caps();
        run(300, 20, 1'b1, 13);
        vectors++; if (cap_t.size() !== 3) begin miscompares++; $display("FAIL rev_pulses: got %0d expected 3", cap_t.size()); end
        for (int i = 0; i < cap_t.size() && i < 3; i++) begin
            exp_vel = (i == 0) ? 9'd7 : 9'd5;
            vectors++; if (cap_t[i] !== 90 + 100 * i) begin miscompares++; $display("FAIL rev_t[%0d]: got %0d expected %0d", i, cap_t[i], 90 + 100 * i); end
            vectors++; if (cap_vel[i] !== exp_vel) begin miscompares++; $display("FAIL rev_vel[%0d]: got %0d expected %0d", i, cap_vel[i], exp_vel); end
            vectors++; if (cap_dir[i] !== 1'b1) begin miscompares++; $display("FAIL rev_dir[%0d]: got %b expected 1", i, cap_dir[i]); end
            vectors++; if (cap_err[i] !== 1'b0) begin miscompares++; $display("FAIL rev_err[%0d]: got %b expected 0", i, cap_err[i]); end
        end
    endtask

    task automatic test_illegal();
        logic [8:0] exp_vel [3];
        logic       exp_dir [3];
        logic       exp_err [3];
        exp_vel = '{9'd0, 9'd2, 9'd2};
        exp_dir = '{1'b1, 1'b0, 1'b0};
        exp_err = '{1'b0, 1'b1, 1'b0};
        rel = 0;
        clear_caps();
        run(100, 0, 1'b0, 0);
        pos  = (pos + 2) % 6;
        hall = seq[pos];
        run(20, 0, 1'b0, 0);
        step(1'b0);
        run(20, 0, 1'b0, 0);
        hall = 3'b111;
        run(1, 0, 1'b0, 0);
        hall = seq[pos];
        run(19, 0, 1'b0, 0);
        step(1'b0);
        run(40, 0, 1'b0, 0);
        step(1'b0);
        run(20, 0, 1'b0, 0);
        step(1'b0);
        run(80, 0, 1'b0, 0);
        vectors++; if (cap_t.size() !== 3) begin miscompares++; $display("FAIL ill_pulses: got %0d expected 3", cap_t.size()); end
        for (int i = 0; i < cap_t.size() && i < 3; i++) begin
            vectors++; if (cap_vel[i] !== exp_vel[i]) begin miscompares++; $display("FAIL ill_vel[%0d]: got %0d expected %0d", i, cap_vel[i], exp_vel[i]); end
            vectors++; if (cap_dir[i] !== exp_dir[i]) begin miscompares++; $display("FAIL ill_dir[%0d]: got %b expected %b", i, cap_dir[i], exp_dir[i]); end
            vectors++; if (cap_err[i] !== exp_err[i]) begin miscompares++; $display("FAIL ill_err[%0d]: got %b expected %b", i, cap_err[i], exp_err[i]); end
        end
    endtask

    // 2000-cycle window, forward step every 2 cycles: ~1000 edges saturate at 511.
    task automatic test_saturation();
        int         pb;
        int         npulse;
        int         t_pulse;
        logic [8:0] v;
        logic       d;
        logic       e;
        pb      = 0;
        npulse  = 0;
        t_pulse = 0;
        v       = 9'd0;
        d       = 1'b1;
        e       = 1'b1;
        @(posedge clk);
        #1;
        rst_n_big = 1'b1;
        en_big    = 1'b1;
        for (int i = 1; i <= 2010; i++) begin
            @(posedge clk);
            #1;
            if (vel_valid_big === 1'b1) begin
                npulse++;
                t_pulse = i;
                v = current_vel_big;
                d = dir_big;
                e = hall_err_big;
            end
            if (i % 2 == 0) begin
                pb       = (pb + 1) % 6;
                hall_big = seq[pb];
            end
        end
        vectors++; if (npulse !== 1) begin miscompares++; $display("FAIL sat_pulses: got %0d expected 1", npulse); end
        vectors++; if (t_pulse !== 2000) begin miscompares++; $display("FAIL sat_t: got %0d expected 2000", t_pulse); end
        vectors++; if (v !== 9'd511) begin miscompares++; $display("FAIL sat_vel: got %0d expected 511", v); end
        vectors++; if (d !== 1'b0) begin miscompares++; $display("FAIL sat_dir: got %b expected 0", d); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL sat_err: got %b expected 0", e); end
    endtask

    task automatic test_reset_and_enable();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel   = 0;
        clear_caps();
        run(130, 5, 1'b0, 0);
        vectors++; if (cap_t.size() !== 1) begin miscompares++; $display("FAIL en_first_pulses: got %0d expected 1", cap_t.size()); end
        if (cap_t.size() > 0) begin
            vectors++; if (cap_t[0] !== 100) begin miscompares++; $display("FAIL en_first_t: got %0d expected 100", cap_t[0]); end
            vectors++; if (cap_vel[0] !== 9'd19) begin miscompares++; $display("FAIL en_first_vel: got %0d expected 19", cap_vel[0]); end
        end

        en = 1'b0;
        clear_caps();
        run(30, 5, 1'b0, 0);
        vectors++; if (cap_t.size() !== 0) begin miscompares++; $display("FAIL en_low_pulses: got %0d expected 0", cap_t.size()); end
        vectors++; if (current_vel !== 9'd19) begin miscompares++; $display("FAIL en_low_hold: got %0d expected 19", current_vel); end

        en = 1'b1;
        clear_caps();
        run(110, 5, 1'b0, 0);
        vectors++; if (cap_t.size() !== 1) begin miscompares++; $display("FAIL en_rise_pulses: got %0d expected 1", cap_t.size()); end
        if (cap_t.size() > 0) begin
            vectors++; if (cap_t[0] !== 260) begin miscompares++; $display("FAIL en_rise_t: got %0d expected 260", cap_t[0]); end
            vectors++; if (cap_vel[0] !== 9'd20) begin miscompares++; $display("FAIL en_rise_vel: got %0d expected 20", cap_vel[0]); end
        end

        run(40, 5, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        vectors++; if (current_vel !== 9'd0) begin miscompares++; $display("FAIL midrst_vel: got %0d expected 0", current_vel); end
        vectors++; if (dir !== 1'b0) begin miscompares++; $display("FAIL midrst_dir: got %b expected 0", dir); end
        vectors++; if (hall_err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b expected 0", hall_err); end
        clear_caps();
        run(5, 5, 1'b0, 0);
        rst_n = 1'b1;
        rel   = 0;
        run(105, 5, 1'b0, 0);
        vectors++; if (cap_t.size() !== 1) begin miscompares++; $display("FAIL midrst_pulses: got %0d expected 1", cap_t.size()); end
        if (cap_t.size() > 0) begin
            vectors++; if (cap_t[0] !== 100) begin miscompares++; $display("FAIL midrst_t: got %0d expected 100", cap_t[0]); end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rel         = 0;
        rst_n       = 1'b0;
        rst_n_big   = 1'b0;
        en          = 1'b0;
        en_big      = 1'b0;
        hall        = 3'b001;
        hall_big    = 3'b001;
        test_reset();
        test_forward();
        test_reverse();
        test_illegal();
        test_saturation();
        test_reset_and_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
